// File: rtl/fp_class_pipe_pkg.sv
// ---------------------------------------------------------------
// fp_class_pipe_pkg : fclass bit indices shared by the classifier
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package fp_class_pipe_pkg;

  localparam int CLS_W    = 10;

  localparam int FC_NINF  = 0;
  localparam int FC_NNORM = 1;
  localparam int FC_NSUB  = 2;
  localparam int FC_NZERO = 3;
  localparam int FC_PZERO = 4;
  localparam int FC_PSUB  = 5;
  localparam int FC_PNORM = 6;
  localparam int FC_PINF  = 7;
  localparam int FC_SNAN  = 8;
  localparam int FC_QNAN  = 9;

endpackage

`default_nettype wire

// File: rtl/fp_elem_class.sv
// ---------------------------------------------------------------
// fp_elem_class : two-stage decode + one-hot classify of one element
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module fp_elem_class
  import fp_class_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               i_ld1,
  input  logic               i_ld2,
  input  logic [EXP_W+MAN_W:0] i_elem,
  input  logic               i_en,
  output logic [CLS_W-1:0]   o_cls,
  output logic               o_nan,
  output logic               o_inv
);

  logic r_exp_ones, r_exp_zero, r_man_zero, r_man_msb, r_sign;
  logic [CLS_W-1:0] r_cls;
  logic r_nan, r_inv;

  logic [CLS_W-1:0] w_cls;
  logic w_nan, w_inf, w_zero, w_sub, w_norm;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_exp_ones <= 1'b0;
      r_exp_zero <= 1'b0;
      r_man_zero <= 1'b0;
      r_man_msb  <= 1'b0;
      r_sign     <= 1'b0;
    end else if (i_ld1) begin
      r_exp_ones <= &i_elem[MAN_W +: EXP_W];
      r_exp_zero <= ~|i_elem[MAN_W +: EXP_W];
      r_man_zero <= ~|i_elem[MAN_W-1:0];
      r_man_msb  <= i_elem[MAN_W-1];
      r_sign     <= i_elem[EXP_W+MAN_W];
    end
  end

  assign w_nan  = r_exp_ones & ~r_man_zero;
  assign w_inf  = r_exp_ones &  r_man_zero;
  assign w_zero = r_exp_zero &  r_man_zero;
  assign w_sub  = r_exp_zero & ~r_man_zero;
  assign w_norm = ~r_exp_ones & ~r_exp_zero;

  // i_en is the stage-1 mask bit; a disabled lane yields an all-zero class
  always_comb begin
    w_cls = '0;
    if (i_en) begin
      w_cls[FC_NINF]  = w_inf  &  r_sign;
      w_cls[FC_NNORM] = w_norm &  r_sign;
      w_cls[FC_NSUB]  = w_sub  &  r_sign;
      w_cls[FC_NZERO] = w_zero &  r_sign;
      w_cls[FC_PZERO] = w_zero & ~r_sign;
      w_cls[FC_PSUB]  = w_sub  & ~r_sign;
      w_cls[FC_PNORM] = w_norm & ~r_sign;
      w_cls[FC_PINF]  = w_inf  & ~r_sign;
      w_cls[FC_SNAN]  = w_nan  & ~r_man_msb;
      w_cls[FC_QNAN]  = w_nan  &  r_man_msb;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cls <= '0;
      r_nan <= 1'b0;
      r_inv <= 1'b0;
    end else if (i_ld2) begin
      r_cls <= w_cls;
      r_nan <= i_en & w_nan;
      r_inv <= i_en & w_nan & ~r_man_msb;
    end
  end

  assign o_cls = r_cls;
  assign o_nan = r_nan;
  assign o_inv = r_inv;

endmodule

`default_nettype wire

// File: rtl/fp_class_pipe.sv
// ---------------------------------------------------------------
// fp_class_pipe : multi-lane fclass pipeline with valid/ready and sticky NV
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module fp_class_pipe
  import fp_class_pipe_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [NLANES*(1+EXP_W+MAN_W)-1:0] opa_i,
  input  logic [NLANES*(1+EXP_W+MAN_W)-1:0] opb_i,
  input  logic [NLANES-1:0]          mask_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [NLANES*CLS_W-1:0]    cls_a_o,
  output logic [NLANES*CLS_W-1:0]    cls_b_o,
  output logic [NLANES-1:0]          nan_o,
  output logic [NLANES-1:0]          inv_o,
  input  logic                       clr_i,
  output logic                       nv_o
);

  localparam int EW = 1 + EXP_W + MAN_W;

  logic r_v1, r_v2, r_nv;
  logic [NLANES-1:0] r_mask;

  logic w_ld1, w_ld2, w_acc, w_fill2;
  logic [NLANES-1:0] w_nan_a, w_nan_b, w_inv_a, w_inv_b;

  // A stage loads when empty or when its content leaves this cycle
  assign w_ld2   = ~r_v2 | ready_i;
  assign w_ld1   = ~r_v1 | w_ld2;
  assign w_acc   = valid_i & w_ld1;
  assign w_fill2 = r_v1 & w_ld2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_mask <= '0;
      r_nv   <= 1'b0;
    end else begin
      if (w_ld1) r_v1 <= valid_i;
      if (w_ld2) r_v2 <= r_v1;
      if (w_acc) r_mask <= mask_i;
      if (r_v2 && ready_i && (|inv_o)) r_nv <= 1'b1;
      else if (clr_i)                  r_nv <= 1'b0;
    end
  end

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    fp_elem_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_ld1  (w_acc),
      .i_ld2  (w_fill2),
      .i_elem (opa_i[k*EW +: EW]),
      .i_en   (r_mask[k]),
      .o_cls  (cls_a_o[k*CLS_W +: CLS_W]),
      .o_nan  (w_nan_a[k]),
      .o_inv  (w_inv_a[k])
    );
    fp_elem_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_ld1  (w_acc),
      .i_ld2  (w_fill2),
      .i_elem (opb_i[k*EW +: EW]),
      .i_en   (r_mask[k]),
      .o_cls  (cls_b_o[k*CLS_W +: CLS_W]),
      .o_nan  (w_nan_b[k]),
      .o_inv  (w_inv_b[k])
    );
  end

  assign nan_o   = w_nan_a | w_nan_b;
  assign inv_o   = w_inv_a | w_inv_b;
  assign ready_o = w_ld1;
  assign valid_o = r_v2;
  assign nv_o    = r_nv;

endmodule

`default_nettype wire

// File: tb/tb_fp_class_pipe.sv
// ---------------------------------------------------------------
// tb_fp_class_pipe : scoreboard bench for fp_class_pipe (FP32 and FP16 builds)
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_fp_class_pipe;

  typedef struct packed {
    logic [39:0] ca;
    logic [39:0] cb;
    logic [3:0]  nan;
    logic [3:0]  inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_i, ready_i, clr_i;
  logic [127:0] opa_i, opb_i;
  logic [3:0] mask_i;
  logic ready_o, valid_o, nv_o;
  logic [39:0] cls_a_o, cls_b_o;
  logic [3:0] nan_o, inv_o;

  logic v2_i, r2_i, clr2_i;
  logic [63:0] a2_i, b2_i;
  logic [3:0] m2_i;
  logic rdy2_o, vld2_o, nv2_o;
  logic [39:0] ca2_o, cb2_o;
  logic [3:0] nan2_o, inv2_o;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fp_class_pipe dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .opa_i(opa_i), .opb_i(opb_i), .mask_i(mask_i), .valid_o(valid_o),
    .ready_i(ready_i), .cls_a_o(cls_a_o), .cls_b_o(cls_b_o),
    .nan_o(nan_o), .inv_o(inv_o), .clr_i(clr_i), .nv_o(nv_o)
  );

  fp_class_pipe #(.NLANES(4), .EXP_W(5), .MAN_W(10)) dut_h (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v2_i), .ready_o(rdy2_o),
    .opa_i(a2_i), .opb_i(b2_i), .mask_i(m2_i), .valid_o(vld2_o),
    .ready_i(r2_i), .cls_a_o(ca2_o), .cls_b_o(cb2_o),
    .nan_o(nan2_o), .inv_o(inv2_o), .clr_i(clr2_i), .nv_o(nv2_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  // Reference fclass for one FP32 element
  function automatic logic [9:0] mcls(input logic [31:0] x);
    logic [7:0] e;
    logic [22:0] m;
    e = x[30:23];
    m = x[22:0];
    if (e == 8'hFF) begin
      if (m == 23'd0) return x[31] ? 10'h001 : 10'h080;
      return m[22] ? 10'h200 : 10'h100;
    end
    if (e == 8'h00) begin
      if (m == 23'd0) return x[31] ? 10'h008 : 10'h010;
      return x[31] ? 10'h004 : 10'h020;
    end
    return x[31] ? 10'h002 : 10'h040;
  endfunction

  function automatic exp_t mexp(input logic [127:0] a, input logic [127:0] b, input logic [3:0] m);
    exp_t e;
    logic [9:0] ca, cb;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        ca = mcls(a[k*32 +: 32]);
        cb = mcls(b[k*32 +: 32]);
        e.ca[k*10 +: 10] = ca;
        e.cb[k*10 +: 10] = cb;
        e.nan[k] = ca[8] | ca[9] | cb[8] | cb[9];
        e.inv[k] = ca[8] | cb[8];
      end
    end
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [127:0] a, input logic [127:0] b, input logic [3:0] m, input exp_t e);
    bit ok;
    ok = 1'b0;
    opa_i = a; opb_i = b; mask_i = m; valid_i = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout got ready_o=0 expected ready_o=1");
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic send_m(input logic [127:0] a, input logic [127:0] b, input logic [3:0] m);
    send(a, b, m, mexp(a, b, m));
  endtask

  task automatic drain;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !valid_o) break;
    end
    chk("drain_queue_empty", 128'(sb.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: pop on every handshake, and check outputs hold while stalled
  logic stalled;
  logic [88:0] held;
  exp_t got, want;
  initial stalled = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_stable", 128'({valid_o, cls_a_o, cls_b_o, nan_o, inv_o}), 128'(held));
      stalled = valid_o && !ready_i;
      held = {valid_o, cls_a_o, cls_b_o, nan_o, inv_o};
      if (valid_o && ready_i) begin
        got = {cls_a_o, cls_b_o, nan_o, inv_o};
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat got %h expected no beat", got);
        end else begin
          want = sb.pop_front();
          chk("beat", 128'(got), 128'(want));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end

  logic [127:0] sa [6];
  logic [127:0] sbv[6];

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; clr_i = 1'b0;
    opa_i = '0; opb_i = '0; mask_i = 4'hF;
    v2_i = 1'b0; r2_i = 1'b1; clr2_i = 1'b0; a2_i = '0; b2_i = '0; m2_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 128'({valid_o, ready_o, nv_o, cls_a_o, cls_b_o, nan_o, inv_o}),
        128'({1'b0, 1'b1, 1'b0, 40'd0, 40'd0, 4'd0, 4'd0}));
    rst_n = 1'b1;
    chk("ready_after_reset", 128'(ready_o), 128'd1);

    // Half-precision build: +inf and -zero in lane 0
    a2_i = 64'h0000_0000_0000_7C00; b2_i = 64'h0000_0000_0000_8000; v2_i = 1'b1;
    @(posedge clk); #1; v2_i = 1'b0;
    chk("h_valid_lat1", 128'(vld2_o), 128'd0);
    @(posedge clk); #1;
    chk("h_valid_lat2", 128'(vld2_o), 128'd1);
    chk("h_cls", 128'({ca2_o, cb2_o, nan2_o, inv2_o}),
        128'({10'h010, 10'h010, 10'h010, 10'h080, 10'h010, 10'h010, 10'h010, 10'h008, 4'd0, 4'd0}));
    @(posedge clk); #1;

    // +inf / -zero in lane 0, latency check
    send(128'h0000_0000_0000_0000_0000_0000_7F80_0000, 128'h0000_0000_0000_0000_0000_0000_8000_0000, 4'hF,
         {10'h010, 10'h010, 10'h010, 10'h080, 10'h010, 10'h010, 10'h010, 10'h008, 4'd0, 4'd0});
    chk("lat_cycle1", 128'(valid_o), 128'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", 128'(valid_o), 128'd1);
    drain();
    chk("nv_clear_after_inf", 128'(nv_o), 128'd0);

    // sNaN / qNaN in lane 1
    send(128'h0000_0000_0000_0000_7FA0_0000_0000_0000, 128'h0000_0000_0000_0000_7FC0_0000_0000_0000, 4'hF,
         {10'h010, 10'h010, 10'h100, 10'h010, 10'h010, 10'h010, 10'h200, 10'h010, 4'b0010, 4'b0010});
    drain();
    chk("nv_set", 128'(nv_o), 128'd1);
    clr_i = 1'b1; @(posedge clk); #1; clr_i = 1'b0;
    chk("nv_cleared", 128'(nv_o), 128'd0);

    // Subnormal, normal, -inf, qNaN in lanes 0..3
    send(128'hFFC0_0000_FF80_0000_3F80_0000_0000_0001, 128'd0, 4'hF,
         {10'h200, 10'h001, 10'h040, 10'h020, 10'h010, 10'h010, 10'h010, 10'h010, 4'b1000, 4'b0000});
    drain();
    chk("nv_qnan_only", 128'(nv_o), 128'd0);

    // Six-beat stream with a three-cycle downstream stall
    sa[0] = 128'h4000_0000_C000_0000_0000_0000_8000_0001;
    sa[1] = 128'h7F80_0000_FF80_0000_7FFF_FFFF_0080_0000;
    sa[2] = 128'h807F_FFFF_3F80_0000_0000_0000_FF80_0001;
    sa[3] = 128'h0000_0000_0000_0000_0000_0000_0000_0000;
    sa[4] = 128'h7F7F_FFFF_8080_0000_7FC0_0001_4120_0000;
    sa[5] = 128'h8000_0000_0000_0010_FFFF_FFFF_7F80_0000;
    sbv[0] = 128'h7FC0_0000_0000_0000_3F80_0000_FF80_0000;
    sbv[1] = 128'h0000_0001_8000_0001_C2C8_0000_7F80_0001;
    sbv[2] = 128'h0000_0000_7F80_0000_8000_0000_4040_0000;
    sbv[3] = 128'hFF80_0001_0000_0000_0000_0000_0000_0000;
    sbv[4] = 128'h3F80_0000_3F80_0000_3F80_0000_3F80_0000;
    sbv[5] = 128'h7FA0_0000_BF80_0000_0040_0000_8000_0000;
    fork
      begin
        for (int i = 0; i < 6; i++) send_m(sa[i], sbv[i], (i == 2) ? 4'b1010 : 4'hF);
      end
      begin
        @(posedge clk); #1; ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_drop_full", 128'(ready_o), 128'd0);
        @(posedge clk); #1; ready_i = 1'b1;
      end
    join
    drain();
    clr_i = 1'b1; @(posedge clk); #1; clr_i = 1'b0;

    // Masked lanes with sNaN everywhere; set beats clear in the same cycle
    clr_i = 1'b1;
    send(128'h7F80_0001_7F80_0001_7F80_0001_7F80_0001, 128'h7F80_0001_7F80_0001_7F80_0001_7F80_0001, 4'b0101,
         {10'h000, 10'h100, 10'h000, 10'h100, 10'h000, 10'h100, 10'h000, 10'h100, 4'b0101, 4'b0101});
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid_o && ready_i) break;
    end
    @(posedge clk); #1;
    chk("nv_set_beats_clr", 128'(nv_o), 128'd1);
    clr_i = 1'b0;
    drain();

    // Reset with two beats in flight (nv_o is still set here)
    send_m(sa[1], sbv[1], 4'hF);
    send_m(sa[4], sbv[4], 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flush", 128'({valid_o, ready_o, nv_o, cls_a_o, nan_o, inv_o}),
        128'({1'b0, 1'b1, 1'b0, 40'd0, 4'd0, 4'd0}));
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale_beat", 128'(valid_o), 128'd0);
    send_m(sa[2], sbv[2], 4'hF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
